instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, 2, number of fetched-instruction entries buffered toward decode (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 branch_taken  input  1  redirect request from execute stage.
REQ-006 branch_address  input  `ADDRESS_LEN  redirect target.
REQ-007 imem_address  output  `ADDRESS_LEN  byte address driven to instruction memory.
REQ-008 imem_instruction  input  `WORD_LEN  word returned combinationally by instruction memory for imem_address.
REQ-009 out_valid  output  1  head queue entry is valid for decode.
REQ-010 out_ready  input  1  decode accepts the head entry this cycle.
REQ-011 out_instruction  output  `WORD_LEN  head entry instruction.
REQ-012 out_pc_plus4  output  `ADDRESS_LEN  head entry fetch address + 4.

Function
REQ-013 imem_address SHALL equal the PC register combinationally, zero added latency.
REQ-014 pop SHALL occur when out_valid && out_ready; push SHALL be enabled when queue count < QUEUE_DEPTH or a pop occurs the same cycle.
REQ-015 On push, entry {imem_instruction, PC+4} SHALL be written and PC SHALL advance by 4, modulo 2^ADDRESS_LEN (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-016 When push is not enabled, PC and queue contents SHALL hold.
REQ-017 branch_taken SHALL have priority over push and pop: next PC = {branch_address[ADDRESS_LEN-1:2], 2'b00}, queue count = 0, no push that cycle.
REQ-018 out_valid SHALL be 1 iff count != 0; out_instruction and out_pc_plus4 SHALL be 0 when count == 0.
REQ-019 Latency: instruction at address A SHALL appear on outputs one cycle after PC == A with push enabled, if the queue was empty.
REQ-020 Full + simultaneous pop: push and pop both occur, count unchanged, order preserved.
REQ-021 Entries SHALL be delivered strictly in fetch order; read/write pointers wrap modulo QUEUE_DEPTH.
REQ-022 out_ready while out_valid == 0 SHALL have no effect.

Reset
REQ-023 rst assertion SHALL immediately set PC = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_instruction = 0, out_pc_plus4 = 0, regardless of clk.
REQ-024 Reset mid-operation SHALL discard all queued entries; first fetch after release is at RESET_PC.
REQ-025 Queue storage contents need not be reset.

Structure
REQ-026 `WORD_LEN and `ADDRESS_LEN SHALL come from shared configs.v; no local redefinition.
REQ-027 QUEUE_DEPTH default SHALL be mirrored as `FETCH_QUEUE_DEPTH in configs.v.
REQ-028 Queue SHALL be a sub-module fetch_queue (push, pop, flush, data in/out, count); PC logic stays in the top.

Verification
REQ-029 Reset release, out_ready=1, memory words 0..3 = 32'h11,22,33,44 -> outputs 32'h11/pc+4=4, 22/8, 33/12, 44/16 on consecutive cycles.
REQ-030 out_ready=0 for 5 cycles from reset -> queue fills to 2, imem_address stalls at 0x8, out_instruction stays word 0.
REQ-031 Queue full, out_ready=1 one cycle -> entry for PC 0x0 popped, PC 0x8 pushed, count stays 2, imem_address becomes 0xC.
REQ-032 branch_taken=1, branch_address=0x103 while queue full and out_ready=1 -> next cycle out_valid=0, imem_address=0x100; following cycle out_pc_plus4=0x104.
REQ-033 PC preloaded via branch to 0xFFFF_FFFC -> entry with out_pc_plus4=0, next imem_address=0x0.
REQ-034 rst pulsed between clock edges with 2 entries queued -> out_valid=0 and imem_address=RESET_PC before next edge.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "configs.v"

package instruction_fetch_unit_pkg;

    localparam int ADDR_W              = `ADDRESS_LEN;
    localparam int WORD_W              = `WORD_LEN;
    localparam int DEFAULT_QUEUE_DEPTH = `FETCH_QUEUE_DEPTH;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // One fetched instruction together with its sequential successor address.
    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [ADDR_W-1:0] pc_plus4;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/configs.v
`ifndef CONFIGS_V
`define CONFIGS_V

// Shared datapath widths for the core.
`define WORD_LEN          32
`define ADDRESS_LEN       32

// Default depth of the fetch-to-decode queue.
`define FETCH_QUEUE_DEPTH 2

`endif

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Purpose: in-order FIFO of fetched entries between the PC stage and decode.
// Latency: an entry pushed on edge N is visible at head_data after edge N.
// Backpressure: caller must only push when not full (or popping); flush wins over push/pop.
//
// Ports: clk, rst (async, active-high); push/push_data write at the tail;
// pop retires the head; flush empties the queue; head_data is zero when empty;
// count is the number of valid entries.
`include "configs.v"

module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: PC register plus fetch queue feeding decode; branches redirect and flush.
// Latency: word at imem_address appears on out_* one cycle after it is fetched into an empty queue.
// Backpressure: out_valid/out_ready handshake; fetch stalls (PC holds) while the queue is full and not draining.
//
// Ports: clk, rst (async, active-high); branch_taken/branch_address redirect from execute;
// imem_address/imem_instruction form a combinational memory read; out_valid/out_ready/
// out_instruction/out_pc_plus4 present the oldest fetched entry to decode.
`include "configs.v"

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      branch_taken,
    input  logic [`ADDRESS_LEN-1:0]   branch_address,
    output logic [`ADDRESS_LEN-1:0]   imem_address,
    input  logic [`WORD_LEN-1:0]      imem_instruction,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`WORD_LEN-1:0]      out_instruction,
    output logic [`ADDRESS_LEN-1:0]   out_pc_plus4
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    fetch_entry_t      new_entry;
    fetch_entry_t      head;

    assign imem_address = pc;
    assign out_valid    = (count != '0);

    // A redirect discards everything, so neither pop nor push happens that cycle.
    assign pop  = out_valid && out_ready && !branch_taken;
    assign push = !branch_taken && ((count < CW'(QUEUE_DEPTH)) || pop);

    assign new_entry.instruction = imem_instruction;
    assign new_entry.pc_plus4    = pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= align_word(branch_address);
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (branch_taken),
        .push_data (new_entry),
        .head_data (head),
        .count     (count)
    );

    assign out_instruction = head.instruction;
    assign out_pc_plus4    = head.pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose: randomized and directed bench for instruction_fetch_unit with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_plus4;

    int checks = 0;
    int passes = 0;

    ent_t        model_q[$];
    logic [31:0] model_pc = RST_PC;

    instruction_fetch_unit #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc_plus4     (out_pc_plus4)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: small table at the bottom, address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    assign imem_instruction = mem_word(imem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch happens whenever the queue has room after this cycle's
    // retirement (retirement is removed by the monitor at the preceding falling edge).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            model_pc = RST_PC;
        end else if (branch_taken) begin
            model_q.delete();
            model_pc = branch_address & 32'hFFFF_FFFC;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back('{instr: mem_word(model_pc), pc4: model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
        end
    end

    // Monitor: compare outputs against the scoreboard head, retire on handshake.
    always @(negedge clk) begin
        chk("imem_address", imem_address, model_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
        if (model_q.size() != 0) begin
            chk("out_instruction", out_instruction, model_q[0].instr);
            chk("out_pc_plus4", out_pc_plus4, model_q[0].pc4);
            if (!rst && out_ready && !branch_taken) begin
                void'(model_q.pop_front());
            end
        end else begin
            chk("out_instruction_idle", out_instruction, 32'h0);
            chk("out_pc_plus4_idle", out_pc_plus4, 32'h0);
        end
    end

    task automatic step(input logic r, input logic b, input logic [31:0] a);
        out_ready      = r;
        branch_taken   = b;
        branch_address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_ready    = 1'b0;
        branch_taken = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_pc", imem_address, RST_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] exp_instr [4];
    logic [31:0] ra;

    initial begin
        exp_instr[0] = 32'h11;
        exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33;
        exp_instr[3] = 32'h44;

        // Streaming with decode always ready.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stream_instr", out_instruction, exp_instr[i]);
            chk("stream_pc4", out_pc_plus4, 32'(4 * (i + 1)));
        end

        // Stall: queue fills, PC stops at the third word.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
        end
        chk("stall_addr", imem_address, 32'h8);
        chk("stall_instr", out_instruction, 32'h11);

        // Full queue drains one entry while fetching the next.
        step(1'b1, 1'b0, 32'h0);
        chk("full_pop_addr", imem_address, 32'hC);
        chk("full_pop_instr", out_instruction, 32'h22);
        step(1'b0, 1'b0, 32'h0);
        chk("full_hold_addr", imem_address, 32'hC);

        // Branch with misaligned target while full and ready.
        step(1'b1, 1'b1, 32'h103);
        chk("br_valid", {31'b0, out_valid}, 32'h0);
        chk("br_addr", imem_address, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("br_pc4", out_pc_plus4, 32'h104);

        // Address wrap at the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pre_addr", imem_address, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc4", out_pc_plus4, 32'h0);
        chk("wrap_addr", imem_address, 32'h0);

        // Asynchronous reset between edges with entries queued.
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("pre_arst_valid", {31'b0, out_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_addr", imem_address, RST_PC);
        chk("arst_instr", out_instruction, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0);
        chk("post_arst_instr", out_instruction, 32'h22);

        // Randomized traffic; the monitor checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ra = 32'hFFFF_FFF0 | {28'h0, ra[3:0]};
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), ra);
        end

        step(1'b0, 1'b0, 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
